// File: rtl/pc_pkg.sv
// Shared constants, operation encoding and strobe priority decode for pc_stack_counter.
package pc_pkg;

  localparam int PC_WIDTH_DEF = 12;
  localparam int PC_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_CALL,
    PC_RET
  } pc_op_e;

  // Fixed priority: ret > call > load > en > hold.
  function automatic pc_op_e pc_decode(input logic en, input logic load,
                                       input logic call, input logic ret);
    if (ret)       return PC_RET;
    else if (call) return PC_CALL;
    else if (load) return PC_LOAD;
    else if (en)   return PC_INC;
    else           return PC_HOLD;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO with occupancy count and sticky overflow/underflow flags.
// Only instantiated by pc_stack_counter when PC_RET_STACK_EN is defined.
module ret_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       full,
  output logic                       empty,
  output logic                       err_ovf,
  output logic                       err_unf
);

  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDXW-1:0]  wr_idx;
  logic [IDXW-1:0]  top_idx;

  assign full    = (sp == SPW'(DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = IDXW'(sp);
  assign top_idx = IDXW'(sp - SPW'(1));
  assign dout    = mem[top_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp      <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (push) begin
      if (full) err_ovf <= 1'b1;
      else      sp      <= sp + SPW'(1);
    end else if (pop) begin
      if (empty) err_unf <= 1'b1;
      else       sp      <= sp - SPW'(1);
    end
  end

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with hold/increment/jump/call/return and optional return stack.
// Define PC_RET_STACK_EN to build the stack; otherwise call acts as load and ret holds.
module pc_stack_counter
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH = PC_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           val,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       full,
  output logic                       empty,
  output logic                       err_ovf,
  output logic                       err_unf
);

  pc_op_e           op;
  logic [WIDTH-1:0] q_nxt;

  assign op = pc_decode(en, load, call, ret);

`ifdef PC_RET_STACK_EN
  logic [WIDTH-1:0] stk_top;

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (op == PC_CALL),
    .pop     (op == PC_RET),
    .din     (q + WIDTH'(1)),
    .dout    (stk_top),
    .sp      (sp),
    .full    (full),
    .empty   (empty),
    .err_ovf (err_ovf),
    .err_unf (err_unf)
  );
`else
  assign sp      = '0;
  assign full    = 1'b0;
  assign empty   = 1'b1;
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif

  always_comb begin
    q_nxt = q;
    case (op)
      PC_INC:           q_nxt = q + WIDTH'(1);
      PC_LOAD, PC_CALL: q_nxt = val;
`ifdef PC_RET_STACK_EN
      PC_RET:           if (!empty) q_nxt = stk_top;
`endif
      default:          q_nxt = q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= q_nxt;
  end

endmodule

// File: tb/tb_pc_stack_counter.sv
// Self-checking bench for pc_stack_counter: vector table, corner sequences, random vs. model.
module tb_pc_stack_counter;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             en, load, call, ret;
  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] q;
  logic [SPW-1:0]   sp;
  logic             full, empty, err_ovf, err_unf;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: PC as an integer, return stack as a queue.
  int q_m;
  int stk[$];
  bit ovf_m, unf_m;

  typedef struct {
    bit               en, load, call, ret;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] exp_q;
    string            name;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pc_stack_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .call    (call),
    .ret     (ret),
    .val     (val),
    .q       (q),
    .sp      (sp),
    .full    (full),
    .empty   (empty),
    .err_ovf (err_ovf),
    .err_unf (err_unf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    q_m = 0;
    stk.delete();
    ovf_m = 0;
    unf_m = 0;
  endtask

  task automatic model_op(input bit e, input bit l, input bit c, input bit r, input int v);
    if (r) begin
`ifdef PC_RET_STACK_EN
      if (stk.size() == 0) unf_m = 1;
      else q_m = stk.pop_back();
`endif
    end else if (c) begin
`ifdef PC_RET_STACK_EN
      if (stk.size() == DEPTH) ovf_m = 1;
      else stk.push_back((q_m + 1) & MASK);
`endif
      q_m = v & MASK;
    end else if (l) begin
      q_m = v & MASK;
    end else if (e) begin
      q_m = (q_m + 1) & MASK;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " q"},       32'(q),       32'(q_m));
    check({tag, " sp"},      32'(sp),      32'(stk.size()));
    check({tag, " full"},    32'(full),    32'(stk.size() == DEPTH));
    check({tag, " empty"},   32'(empty),   32'(stk.size() == 0));
    check({tag, " err_ovf"}, 32'(err_ovf), 32'(ovf_m));
    check({tag, " err_unf"}, 32'(err_unf), 32'(unf_m));
  endtask

  task automatic step(input bit e, input bit l, input bit c, input bit r, input int v);
    @(negedge clk);
    en = e; load = l; call = c; ret = r;
    val = WIDTH'(v);
    @(posedge clk);
    model_op(e, l, c, r, v);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 0; load = 0; call = 0; ret = 0;
    reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    tbl.push_back('{0, 1, 0, 0, 12'h064, 12'h064, "load 064"});
    for (int i = 1; i <= 5; i++)
      tbl.push_back('{1, 0, 0, 0, 12'h000, WIDTH'(12'h064 + i), "inc"});
    tbl.push_back('{0, 1, 0, 0, 12'hFFE, 12'hFFE, "load FFE"});
    tbl.push_back('{1, 0, 0, 0, 12'h000, 12'hFFF, "inc FFF"});
    tbl.push_back('{1, 0, 0, 0, 12'h000, 12'h000, "inc wrap"});
    tbl.push_back('{1, 0, 0, 0, 12'h000, 12'h001, "inc 001"});
    tbl.push_back('{0, 0, 0, 0, 12'h3C3, 12'h001, "hold"});
    tbl.push_back('{1, 1, 0, 0, 12'h123, 12'h123, "load over en"});
    tbl.push_back('{1, 0, 0, 0, 12'h555, 12'h124, "inc ignores val"});
    tbl.push_back('{0, 0, 0, 0, 12'h777, 12'h124, "hold ignores val"});

    // Reset held with load pending: nothing may load until reset drops.
    reset = 1; en = 0; load = 1; call = 0; ret = 0; val = 12'h064;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    check("reset q", 32'(q), 32'h0);
    @(negedge clk);
    reset = 0; load = 0;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].load, tbl[i].call, tbl[i].ret, int'(tbl[i].val));
      check({"tbl ", tbl[i].name}, 32'(q), 32'(tbl[i].exp_q));
      check_model({"tbl ", tbl[i].name});
    end

`ifdef PC_RET_STACK_EN
    // Nested calls and returns.
    do_reset();
    step(0, 1, 0, 0, 'h010);
    step(0, 0, 1, 0, 'h200);
    step(0, 0, 1, 0, 'h300);
    check("nest q", 32'(q), 32'h300);
    check("nest sp", 32'(sp), 32'd2);
    step(0, 0, 0, 1, 0);
    check("nest ret1 q", 32'(q), 32'h201);
    step(0, 0, 0, 1, 0);
    check("nest ret2 q", 32'(q), 32'h011);
    check("nest empty", 32'(empty), 32'd1);

    // Overflow: fifth call jumps but discards the push.
    do_reset();
    step(0, 1, 0, 0, 'h000);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, 0, 'h100);
      if (i == 4) check("ovf full after 4", 32'(full), 32'd1);
    end
    check("ovf q", 32'(q), 32'h100);
    check("ovf sp", 32'(sp), 32'd4);
    check("ovf flag", 32'(err_ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      check("ovf ret q", 32'(q), (i == 3) ? 32'h001 : 32'h101);
    end
    check_model("ovf end");

    // Underflow, then all strobes high with one entry on the stack.
    do_reset();
    step(0, 1, 0, 0, 'h050);
    step(0, 0, 0, 1, 0);
    check("unf q", 32'(q), 32'h050);
    check("unf flag", 32'(err_unf), 32'd1);
    step(0, 1, 0, 0, 'h122);
    step(0, 0, 1, 0, 'h0AA);
    check("prio sp", 32'(sp), 32'd1);
    step(1, 1, 1, 1, 'h0AA);
    check("prio ret wins q", 32'(q), 32'h123);
    check("prio sp after", 32'(sp), 32'd0);
    check_model("prio");

    // Call immediately followed by return.
    step(0, 1, 0, 0, 'h7FF);
    step(0, 0, 1, 0, 'h444);
    step(0, 0, 0, 1, 0);
    check("call-ret q", 32'(q), 32'h800);
`else
    do_reset();
    step(0, 0, 1, 0, 'h0AA);
    check("nostk call q", 32'(q), 32'h0AA);
    check("nostk call sp", 32'(sp), 32'd0);
    step(0, 0, 0, 1, 0);
    check("nostk ret q", 32'(q), 32'h0AA);
    step(1, 1, 0, 1, 'h333);
    check("nostk ret blocks q", 32'(q), 32'h0AA);
    check_model("nostk");
`endif

    // Randomised run against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, MASK)));
      check_model($sformatf("rand %0d", i));
    end

    // Asynchronous reset between edges with strobes active.
    @(negedge clk);
    en = 1; load = 1; call = 1; ret = 0; val = 12'hABC;
    #2;
    reset = 1;
    #1;
    model_reset();
    check_model("async reset");
    @(negedge clk);
    en = 0; load = 0; call = 0; ret = 0;
    reset = 0;
    step(1, 0, 0, 0, 0);
    check("post reset inc", 32'(q), 32'h001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_stack_counter.md
# pc_stack_counter

Parametrised program counter with a built-in hardware return-address stack, the next generation of the 12-bit program counter in the CPU datapath. It supports hold, increment, absolute load (jump), call (push return address, then jump) and return (pop into the PC). It sits between the control unit, which drives the operation strobes, and the program ROM address bus, which takes `q`.

## Interface
Parameters:
- `WIDTH`, 12: PC and address width in bits.
- `DEPTH`, 4: return-stack entries; must be ≥1.

Ports:
- `clk`  in  1  Single clock; all state updates on rising edge.
- `reset`  in  1  Asynchronous, active-high; clears all state immediately.
- `en`  in  1  Increment: `q <= q + 1`.
- `load`  in  1  Jump: `q <= val`.
- `call`  in  1  Push `q + 1`; `q <= val`.
- `ret`  in  1  Pop top of stack into `q`.
- `val`  in  WIDTH  Target address for `load` and `call`.
- `q`  out  WIDTH  Current PC.
- `sp`  out  $clog2(DEPTH+1)  Number of valid stack entries.
- `full`  out  1  `sp == DEPTH`.
- `empty`  out  1  `sp == 0`.
- `err_ovf`  out  1  Sticky flag: a call was made while the stack was full.
- `err_unf`  out  1  Sticky flag: a return was made while the stack was empty.

## Operation
- Reset values: `q` = 0, `sp` = 0, `empty` = 1, `full` = 0, `err_ovf` = 0, `err_unf` = 0. Stack contents are don't-care after reset.
- When several strobes are high in one cycle, exactly one operation executes, by fixed priority: `ret` > `call` > `load` > `en` > hold.
- Hold (no strobe high): all state is unchanged.
- Increment is modulo 2^WIDTH; all-ones wraps to 0 with no flag.
- Call:
  - Return address = `(q + 1) mod 2^WIDTH`. It is written to `stack[sp]`, `sp` increments, and `q <= val`.
  - If `full`: the jump is still performed, the push is discarded, `sp` stays at DEPTH, and `err_ovf` is set.
- Return:
  - `q <= stack[sp-1]` and `sp` decrements.
  - If `empty`: `q` holds, `sp` stays 0, and `err_unf` is set.
- Error flags clear only on `reset`.
- `val` is sampled only on a `load` or `call` edge.

## Timing
- Every operation has 1-cycle latency: the strobe is sampled at edge N, and `q`/`sp` reflect the result after edge N.
- `full` and `empty` are combinational decodes of registered `sp`; they carry no extra latency.
- Back-to-back calls or returns on consecutive cycles are supported at full rate.
- Call then immediate return on the next cycle: `q` returns to the caller's `q + 1`.
- `reset` asserted mid-operation clears state asynchronously, overriding any strobe. The first operation after deassertion is taken at the first rising edge where `reset` is low.

## Configuration
- Macro: `PC_RET_STACK_EN`.
- Defined: full behaviour as described above.
- Undefined: no stack storage is built.
  - `call` behaves as `load`.
  - `ret` is ignored (hold), but keeps its priority, so it still blocks lower-priority strobes.
  - `sp` = 0, `empty` = 1, `full` = 0, and both error flags tie to 0.

## Structure
- Shared package `pc_pkg`:
  - Default `WIDTH`/`DEPTH` constants.
  - Operation enum `PC_HOLD`, `PC_INC`, `PC_LOAD`, `PC_CALL`, `PC_RET`.
  - The priority-encode function mapping strobes to the enum.
- Sub-module `ret_stack`: LIFO of DEPTH×WIDTH with push/pop, `sp`, full/empty and the sticky error flags. It is instantiated only under `PC_RET_STACK_EN`.
- The top level holds the PC register and the next-PC mux.

## Test plan
Defaults WIDTH=12, DEPTH=4 unless stated.
1. Reset with `load`=1, `val`=0x064 held -> `q`=0x000, `empty`=1, all flags 0. After deassert, `load` for 1 cycle -> `q`=0x064; then `en` for 5 cycles -> `q`=0x069.
2. `q`=0xFFE, `en` for 3 cycles -> `q` = 0xFFF, then 0x000, then 0x001; no flag set.
3. From `q`=0x010: `call` `val`=0x200, then `call` `val`=0x300 -> `q`=0x300, `sp`=2. Then `ret` -> `q`=0x201; `ret` -> `q`=0x011, `empty`=1.
4. Five calls from `q`=0x000 with `val`=0x100 each -> after the 4th, `full`=1; the 5th jumps to 0x100 with `sp`=4 and `err_ovf`=1. Four returns -> `q` = 0x101, 0x101, 0x101, 0x001.
5. `ret` on empty stack at `q`=0x050 -> `q`=0x050, `err_unf`=1. All strobes high with `val`=0x0AA and `sp`=1 (top 0x123) -> `ret` wins, `q`=0x123.
6. Build with `PC_RET_STACK_EN` undefined: `call` `val`=0x0AA -> `q`=0x0AA, `sp`=0. `ret` -> `q` holds at 0x0AA, flags stay 0.
